// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the convolution line-buffer path.
//   pixel_t          - one pixel sample
//   LINE_W_MAX       - widest supported line, in pixels
//   COL_W / col_t    - column counter width and type
//   COL_MAX          - LINE_W_MAX as a col_t, for counter compares
//   lbx_ctrl_state_t - line-buffer controller FSM states
package conv_pkg;

  typedef logic [7:0] pixel_t;

  localparam int LINE_W_MAX = 640;
  localparam int COL_W      = $clog2(LINE_W_MAX + 1);

  typedef logic [COL_W-1:0] col_t;

  localparam col_t COL_MAX = col_t'(LINE_W_MAX);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } lbx_ctrl_state_t;

endpackage

// File: rtl/conv_lbx_ctrl_if.sv
// conv_lbx_ctrl_if: valid-only raster pixel stream into the line-buffer controller.
//   vld - pixel valid (a fire)
//   dat - pixel
//   sof - first pixel of frame, qualified by vld
//   eol - last pixel of line, qualified by vld
// Modports: master drives the stream, slave (the controller) receives it.
interface conv_lbx_ctrl_if;
  import conv_pkg::*;

  logic   vld;
  pixel_t dat;
  logic   sof;
  logic   eol;

  modport master (output vld, output dat, output sof, output eol);
  modport slave  (input  vld, input  dat, input  sof, input  eol);

endinterface

// File: rtl/conv_lbx_ctrl_dly.sv
// conv_lbx_ctrl_dly: LBX_RD_LAT-deep delay line that lines the column
// valid/sof/eol flags and the newest pixel up with the buffer read data.
// Shifts every cycle; all stages clear on asynchronous reset.
//   clk, arst_n                    - clock, async active-low reset
//   vld_i, sof_i, eol_i, dat_i     - column flags and pixel at pop time
//   vld_o, sof_o, eol_o, dat_o     - same, LBX_RD_LAT cycles later
module conv_lbx_ctrl_dly
  import conv_pkg::*;
#(
  parameter int LBX_RD_LAT = 1
) (
  input  logic   clk,
  input  logic   arst_n,
  input  logic   vld_i,
  input  logic   sof_i,
  input  logic   eol_i,
  input  pixel_t dat_i,
  output logic   vld_o,
  output logic   sof_o,
  output logic   eol_o,
  output pixel_t dat_o
);

  logic   vld_p [LBX_RD_LAT];
  logic   sof_p [LBX_RD_LAT];
  logic   eol_p [LBX_RD_LAT];
  pixel_t dat_p [LBX_RD_LAT];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < LBX_RD_LAT; i++) begin
        vld_p[i] <= 1'b0;
        sof_p[i] <= 1'b0;
        eol_p[i] <= 1'b0;
        dat_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= vld_i;
      sof_p[0] <= sof_i;
      eol_p[0] <= eol_i;
      dat_p[0] <= dat_i;
      for (int i = 1; i < LBX_RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        sof_p[i] <= sof_p[i-1];
        eol_p[i] <= eol_p[i-1];
        dat_p[i] <= dat_p[i-1];
      end
    end
  end

  assign vld_o = vld_p[LBX_RD_LAT-1];
  assign sof_o = sof_p[LBX_RD_LAT-1];
  assign eol_o = eol_p[LBX_RD_LAT-1];
  assign dat_o = dat_p[LBX_RD_LAT-1];

endmodule

// File: rtl/conv_lbx_ctrl.sv
// conv_lbx_ctrl: line-buffer controller for the 4-line convolution buffer.
// Turns the raster stream into per-line push/pop strobes and a one-hot
// write-line select, tracks frame fill, and emits a column strobe plus the
// newest pixel aligned to the buffer's read data.
//   clk, arst_n        - clock, async active-low reset
//   s_in (slave)       - pixel stream: vld, dat, sof, eol
//   push_o, pop_o      - per-line push/pop to the buffer (combinational)
//   dat_o, sof_o, eol_o- pixel and frame/line marks to the buffer
//   sel_o              - one-hot current write line (registered)
//   col_vld_o, col_new_o, col_sof_o, col_eol_o - column output, +LBX_RD_LAT
//   err_o              - sticky line-width error
// Optional feature: define CONV_LBX_CTRL_CHK_EN to build the line-width
// checker; otherwise err_o is tied low.
module conv_lbx_ctrl
  import conv_pkg::*;
#(
  parameter int LBX_RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  conv_lbx_ctrl_if.slave       s_in,
  output logic [3:0]           push_o,
  output logic [3:0]           pop_o,
  output pixel_t               dat_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic [3:0]           sel_o,
  output logic                 col_vld_o,
  output pixel_t               col_new_o,
  output logic                 col_sof_o,
  output logic                 col_eol_o,
  output logic                 err_o
);

  lbx_ctrl_state_t state, state_n, state_e;
  logic [3:0] sel, sel_n, sel_e;
  logic [3:0] vlines, vlines_n, vlines_e;
  logic [1:0] row_cnt, row_cnt_n, row_cnt_e;
  logic       first_col, first_col_n;
  logic       restart, acc, col_ld;

  // A sof fire restarts from any state; other fires count only once a frame is open.
  assign restart = s_in.vld & s_in.sof;
  assign acc     = restart | (s_in.vld & (state != IDLE));

  assign dat_o = s_in.dat;
  assign sof_o = s_in.sof & s_in.vld;
  assign eol_o = s_in.eol & s_in.vld;
  assign sel_o = sel;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      sel       <= 4'b0001;
      vlines    <= 4'b0000;
      row_cnt   <= 2'd0;
      first_col <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      vlines    <= vlines_n;
      row_cnt   <= row_cnt_n;
      first_col <= first_col_n;
    end
  end

  always_comb begin
    // "_e" values: current state with a same-cycle restart already applied.
    state_e     = restart ? FILL    : state;
    sel_e       = restart ? 4'b0001 : sel;
    vlines_e    = restart ? 4'b0000 : vlines;
    row_cnt_e   = restart ? 2'd0    : row_cnt;
    state_n     = state;
    sel_n       = sel;
    vlines_n    = vlines;
    row_cnt_n   = row_cnt;
    first_col_n = first_col;
    push_o      = 4'b0000;
    pop_o       = 4'b0000;
    col_ld      = 1'b0;
    if (acc) begin
      push_o      = sel_e;
      pop_o       = vlines_e & ~sel_e;
      col_ld      = (state_e == RUN);
      state_n     = state_e;
      sel_n       = sel_e;
      vlines_n    = vlines_e;
      row_cnt_n   = row_cnt_e;
      first_col_n = restart | (first_col & ~col_ld);
      if (s_in.eol) begin
        vlines_n  = vlines_e | sel_e;
        sel_n     = {sel_e[2:0], sel_e[3]};
        row_cnt_n = (row_cnt_e == 2'd3) ? 2'd3 : row_cnt_e + 2'd1;
        if ((state_e == FILL) && (row_cnt_e == 2'd2)) begin
          state_n = RUN;
        end
      end
    end
  end

  conv_lbx_ctrl_dly #(
    .LBX_RD_LAT (LBX_RD_LAT)
  ) u_dly (
    .clk    (clk),
    .arst_n (arst_n),
    .vld_i  (col_ld),
    .sof_i  (col_ld & first_col),
    .eol_i  (col_ld & s_in.eol),
    .dat_i  (s_in.dat),
    .vld_o  (col_vld_o),
    .sof_o  (col_sof_o),
    .eol_o  (col_eol_o),
    .dat_o  (col_new_o)
  );

`ifdef CONV_LBX_CTRL_CHK_EN
  // Column position is only consumed by the width checker, so it lives here.
  col_t col_cnt, col_len, cnt_e;
  logic len_vld, len_vld_e, err, err_hit;

  always_comb begin
    cnt_e     = restart ? '0   : col_cnt;
    len_vld_e = restart ? 1'b0 : len_vld;
    err_hit   = 1'b0;
    if (acc) begin
      if (len_vld_e && (s_in.eol ? (cnt_e != col_len) : (cnt_e == col_len))) begin
        err_hit = 1'b1;
      end
      if (cnt_e == COL_MAX) begin
        err_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col_cnt <= '0;
      col_len <= '0;
      len_vld <= 1'b0;
      err     <= 1'b0;
    end else if (acc) begin
      col_cnt <= s_in.eol ? '0 : ((cnt_e == COL_MAX) ? COL_MAX : cnt_e + col_t'(1));
      if (s_in.eol && !len_vld_e) begin
        col_len <= cnt_e;
        len_vld <= 1'b1;
      end else begin
        len_vld <= len_vld_e;
      end
      err <= (err & ~restart) | err_hit;
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv_lbx_ctrl.sv
module tb_conv_lbx_ctrl;
  import conv_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    bit     v;
    pixel_t n;
    bit     s;
    bit     e;
  } col_exp_t;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] push_o, pop_o, sel_o;
  pixel_t     dat_o, col_new_o;
  logic       sof_o, eol_o, col_vld_o, col_sof_o, col_eol_o, err_o;

  conv_lbx_ctrl_if s_if ();

  conv_lbx_ctrl #(
    .LBX_RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .s_in      (s_if),
    .push_o    (push_o),
    .pop_o     (pop_o),
    .dat_o     (dat_o),
    .sof_o     (sof_o),
    .eol_o     (eol_o),
    .sel_o     (sel_o),
    .col_vld_o (col_vld_o),
    .col_new_o (col_new_o),
    .col_sof_o (col_sof_o),
    .col_eol_o (col_eol_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: frame-level bookkeeping.
  bit       active;   // a sof has been seen since reset
  int       k;        // completed lines since the last sof
  int       pix;      // pixel index within the current line
  bit       first;    // next column is the first of the frame
  bit       m_err;
  bit       len_v;
  int       width;    // line width captured at the first eol
  col_exp_t colq[$];  // expected column outputs, oldest first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    col_exp_t z;
    z = '{1'b0, 8'h00, 1'b0, 1'b0};
    active = 1'b0; k = 0; pix = 0; first = 1'b0;
    m_err = 1'b0; len_v = 1'b0; width = 0;
    colq.delete();
    for (int i = 0; i < LAT; i++) colq.push_back(z);
  endtask

  // Lines stored before the current one, excluding the line being overwritten.
  function automatic logic [3:0] pop_model(input int lines_done);
    logic [3:0] m;
    m = 4'b0000;
    for (int j = 1; j <= 3 && j <= lines_done; j++) m[(lines_done - j) % 4] = 1'b1;
    return m;
  endfunction

  task automatic step(input bit v, input bit s, input bit e, input pixel_t d);
    col_exp_t   ce, ne;
    bit         acc, col;
    logic [3:0] xp, xo;
    s_if.vld = v; s_if.sof = s; s_if.eol = e; s_if.dat = d;
    #2;
    chk("sel_o", sel_o, 32'(1 << (k % 4)));
    ce = colq[0];
    chk("col_vld_o", col_vld_o, ce.v);
    chk("col_sof_o", col_sof_o, ce.s);
    chk("col_eol_o", col_eol_o, ce.e);
    if (ce.v) chk("col_new_o", col_new_o, ce.n);
    chk("err_o", err_o, m_err);
    if (v && s) begin
      active = 1'b1; k = 0; pix = 0; first = 1'b1; m_err = 1'b0; len_v = 1'b0;
    end
    acc = v && active;
    xp  = acc ? 4'(1 << (k % 4)) : 4'b0000;
    xo  = acc ? pop_model(k) : 4'b0000;
    chk("push_o", push_o, xp);
    chk("pop_o", pop_o, xo);
    chk("dat_o", dat_o, d);
    chk("sof_o", sof_o, v && s);
    chk("eol_o", eol_o, v && e);
    col = acc && (k >= 3);
    ne  = '{col, d, col && first, col && e};
    if (col) first = 1'b0;
`ifdef CONV_LBX_CTRL_CHK_EN
    if (acc) begin
      if (len_v && (e ? (pix + 1 != width) : (pix + 1 == width))) m_err = 1'b1;
      if (pix >= LINE_W_MAX) m_err = 1'b1;
      if (e && !len_v) begin width = pix + 1; len_v = 1'b1; end
    end
`endif
    if (acc) begin
      if (e) begin k++; pix = 0; end
      else pix++;
    end
    colq.push_back(ne);
    void'(colq.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic line(input int w, input bit with_sof);
    for (int i = 0; i < w; i++) step(1'b1, with_sof && (i == 0), i == w - 1, 8'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel_o"}, sel_o, 4'b0001);
    chk({tag, "_col_vld_o"}, col_vld_o, 1'b0);
    chk({tag, "_col_sof_o"}, col_sof_o, 1'b0);
    chk({tag, "_col_eol_o"}, col_eol_o, 1'b0);
    chk({tag, "_col_new_o"}, col_new_o, 8'h00);
    chk({tag, "_err_o"}, err_o, 1'b0);
    chk({tag, "_push_o"}, push_o, 4'b0000);
    chk({tag, "_pop_o"}, pop_o, 4'b0000);
  endtask

  int rw, rrows, rlen;

  initial begin
    arst_n   = 1'b0;
    s_if.vld = 1'b0; s_if.sof = 1'b0; s_if.eol = 1'b0; s_if.dat = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    s_if.vld = 1'b1; s_if.dat = 8'h11;
    #1;
    check_reset_outputs("rst");
    arst_n = 1'b1;

    // Fires with no sof are ignored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i == 2, 8'($urandom));

    // Width-4 frame, 5 rows.
    line(4, 1'b1);
    for (int r = 1; r < 5; r++) line(4, 1'b0);
    idle(3);

    // Sof in row 3, column 2, then a full refill.
    line(4, 1'b1);
    line(4, 1'b0);
    line(4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h31);
    step(1'b1, 1'b0, 1'b0, 8'h32);
    line(4, 1'b1);
    for (int r = 1; r < 4; r++) line(4, 1'b0);
    idle(3);

    // Width-1 frame: sof and eol together on the first fire.
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'b1, 8'($urandom));
    idle(3);

    // Widths 8, 8, then a short line, then more, then a clearing sof.
    line(8, 1'b1);
    line(8, 1'b0);
    line(6, 1'b0);
    line(8, 1'b0);
    idle(2);
    line(8, 1'b1);
    line(8, 1'b0);
    idle(2);

    // Randomised frames with gaps and occasional odd-length lines.
    for (int f = 0; f < 8; f++) begin
      rw    = $urandom_range(1, 6);
      rrows = $urandom_range(2, 6);
      for (int r = 0; r < rrows; r++) begin
        rlen = rw;
        if ($urandom_range(0, 9) == 0) rlen = $urandom_range(1, 7);
        for (int i = 0; i < rlen; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          step(1'b1, (r == 0) && (i == 0), i == rlen - 1, 8'($urandom));
        end
      end
    end
    idle(3);

    // Reset in the middle of RUN, then a normal restart.
    line(3, 1'b1);
    for (int r = 1; r < 4; r++) line(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h77);
    s_if.vld = 1'b1; s_if.sof = 1'b0; s_if.eol = 1'b0; s_if.dat = 8'h5a;
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1;
    arst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h01);
    line(3, 1'b1);
    for (int r = 1; r < 5; r++) line(3, 1'b0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
